// File: rtl/queue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// queue_ctrl
//   Queue occupancy controller. Two raw, asynchronous presence sensors (rear =
//   entry, front = exit) are synchronized and debounced. Each accepted press
//   gives a one-cycle event. The events drive a saturating head count and a
//   wait-time value (count * WAIT_PER_PERSON) that feeds the 7-segment decoder.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   rear_sensor  in   raw entry sensor, high = person present
//   front_sensor in   raw exit sensor, high = person present
//   clr_err      in   synchronous pulse that clears ovf_err / udf_err
//   count        out  people currently in the queue
//   wtime        out  count * WAIT_PER_PERSON, zero-extended to 5 bits
//   full / empty out  count == MAX_COUNT / count == 0
//   entry_evt    out  one-cycle pulse for an accepted entry
//   exit_evt     out  one-cycle pulse for an accepted exit
//   ovf_err      out  sticky: entry accepted while full
//   udf_err      out  sticky: exit accepted while empty
// -----------------------------------------------------------------------------
module queue_ctrl #(
    parameter int MAX_COUNT       = 7,
    parameter int WAIT_PER_PERSON = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rear_sensor,
    input  logic             front_sensor,
    input  logic             clr_err,
    output logic [CNT_W-1:0] count,
    output logic [4:0]       wtime,
    output logic             full,
    output logic             empty,
    output logic             entry_evt,
    output logic             exit_evt,
    output logic             ovf_err,
    output logic             udf_err
);

    // The 5-bit wait-time bus and the count width must hold the worst case.
    if (MAX_COUNT * WAIT_PER_PERSON > 31) begin : g_wtime_range_bad
        $fatal(1, "queue_ctrl: MAX_COUNT*WAIT_PER_PERSON exceeds 31");
    end
    if ((2 ** CNT_W) - 1 < MAX_COUNT) begin : g_cnt_w_bad
        $fatal(1, "queue_ctrl: CNT_W too narrow for MAX_COUNT");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_deb_bad
        $fatal(1, "queue_ctrl: DEBOUNCE_CYCLES must be at least 2");
    end

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]    DCNT_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0]    DCNT_ONE  = DW'(1);
    localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } deb_state_e;

    // Index 0 is the rear (entry) sensor, index 1 the front (exit) sensor.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    deb_state_e       st_q   [2];
    deb_state_e       st_d   [2];
    logic [DW-1:0]    dcnt_q [2];
    logic [DW-1:0]    dcnt_d [2];
    logic [1:0]       evt_q;
    logic [1:0]       evt_d;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [4:0]       wtime_q;
    logic [4:0]       wtime_d;
    logic             full_q;
    logic             full_d;
    logic             empty_q;
    logic             empty_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;
    logic             ovf_set_s;
    logic             udf_set_s;

    assign raw_s = {front_sensor, rear_sensor};

    // Debounce next-state: qualify a press, hold it, then require a clean release.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]   = st_q[i];
            dcnt_d[i] = dcnt_q[i];
            evt_d[i]  = 1'b0;
            case (st_q[i])
                ST_IDLE: begin
                    if (sync2_q[i]) begin
                        st_d[i] = ST_QUAL;
                    end else begin
                        st_d[i] = ST_IDLE;
                    end
                    dcnt_d[i] = DCNT_ZERO;
                end
                ST_QUAL: begin
                    if (!sync2_q[i]) begin
                        st_d[i]   = ST_IDLE;
                        dcnt_d[i] = DCNT_ZERO;
                    end else if (dcnt_q[i] == DCNT_LAST) begin
                        st_d[i]   = ST_HELD;
                        dcnt_d[i] = DCNT_ZERO;
                        evt_d[i]  = 1'b1;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        st_d[i] = ST_REL;
                    end else begin
                        st_d[i] = ST_HELD;
                    end
                    dcnt_d[i] = DCNT_ZERO;
                end
                ST_REL: begin
                    // A bounce back high during release rejoins HELD without a new event.
                    if (sync2_q[i]) begin
                        st_d[i]   = ST_HELD;
                        dcnt_d[i] = DCNT_ZERO;
                    end else if (dcnt_q[i] == DCNT_LAST) begin
                        st_d[i]   = ST_IDLE;
                        dcnt_d[i] = DCNT_ZERO;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
                    end
                end
                default: begin
                    st_d[i]   = ST_IDLE;
                    dcnt_d[i] = DCNT_ZERO;
                end
            endcase
        end
    end

    // Count, derived displays and sticky error flags; simultaneous events cancel.
    always_comb begin
        count_d   = count_q;
        ovf_set_s = 1'b0;
        udf_set_s = 1'b0;
        if (evt_q[0] && !evt_q[1]) begin
            if (count_q == CNT_MAX) begin
                ovf_set_s = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (evt_q[1] && !evt_q[0]) begin
            if (count_q == CNT_ZERO) begin
                udf_set_s = 1'b1;
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
        wtime_d = 5'(32'(count_d) * WAIT_PER_PERSON);
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == CNT_ZERO);
        // A new error in the same cycle as clr_err stays set.
        ovf_d   = ovf_set_s | (ovf_q & ~clr_err);
        udf_d   = udf_set_s | (udf_q & ~clr_err);
    end

    // All state: synchronizers, debounce FSMs, events, count and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= ST_IDLE;
                dcnt_q[i] <= DCNT_ZERO;
            end
            evt_q   <= 2'b00;
            count_q <= CNT_ZERO;
            wtime_q <= 5'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                st_q[i]   <= st_d[i];
                dcnt_q[i] <= dcnt_d[i];
            end
            evt_q   <= evt_d;
            count_q <= count_d;
            wtime_q <= wtime_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count     = count_q;
    assign wtime     = wtime_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign entry_evt = evt_q[0];
    assign exit_evt  = evt_q[1];
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;

endmodule
